// File: rtl/seq_mult_if.sv
// Request/response bundle for the seq_mult shift-add multiplier.
// The requester drives operands and start; the multiplier returns busy, done and result.
interface seq_mult_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   signed_mode;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     result;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    output signed_mode,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    input  signed_mode,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one add-and-shift step per clock, fixed WIDTH+2 cycle
// throughput, unsigned or two's-complement operands selected per operation.
module seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [PW-1:0]        prod_q;
  logic [WIDTH-1:0]     mcand_q;
  logic                 neg_q;
  logic [CW-1:0]        cnt_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]     mag_a_d;
  logic [WIDTH-1:0]     mag_b_d;
  logic                 neg_d;
  logic [WIDTH:0]       upper_d;
  logic [PW-1:0]        prod_d;
  logic [2*WIDTH-1:0]   final_d;

  // Signed operands are reduced to magnitudes; -2^(W-1) negates to itself, which is
  // exactly its magnitude when read as unsigned.
  always_comb begin
    mag_a_d = bus.multiplicand;
    mag_b_d = bus.multiplier;
    neg_d   = 1'b0;
    if (bus.signed_mode) begin
      if (bus.multiplicand[WIDTH-1]) mag_a_d = -bus.multiplicand;
      if (bus.multiplier[WIDTH-1])   mag_b_d = -bus.multiplier;
      neg_d = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
    end
  end

  // The carry lands in prod[2W] and is shifted back into bit 2W-1 on the same step.
  always_comb begin
    upper_d = prod_q[PW-1:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d  = {upper_d, prod_q[WIDTH-1:0]} >> 1;
    final_d = neg_q ? -prod_d[2*WIDTH-1:0] : prod_d[2*WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prod_q   <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q <= mag_a_d;
            prod_q  <= {{(WIDTH + 1){1'b0}}, mag_b_d};
            neg_q   <= neg_d;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_q <= final_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
